// File: rtl/spi_maestro_byte_pkg.sv
// spi_pkg: shared FSM state type, SPI mode constants and default sizing for spi_maestro_byte.
// No ports.
package spi_pkg;
    typedef enum logic [1:0] {REPOSO, PREPARA, ALTO, BAJO} estado_t;
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;
    localparam int ANCHO_DEF = 8;
    localparam int DIV_DEF = 4;
endpackage

// File: rtl/spi_maestro_byte_if.sv
// spi_maestro_byte_if: control handshake and SPI pins of the byte engine.
// Signals: inicio, dato_tx, ocupado, listo, dato_rx (control side); sclk, mosi, miso, cs_n (pin side).
// master = the engine, slave = the environment driving it.
interface spi_maestro_byte_if #(parameter int ANCHO = spi_pkg::ANCHO_DEF);
    logic             inicio;
    logic [ANCHO-1:0] dato_tx;
    logic             miso;
    logic             sclk;
    logic             mosi;
    logic             cs_n;
    logic             ocupado;
    logic             listo;
    logic [ANCHO-1:0] dato_rx;
    modport master (input inicio, dato_tx, miso, output sclk, mosi, cs_n, ocupado, listo, dato_rx);
    modport slave (output inicio, dato_tx, miso, input sclk, mosi, cs_n, ocupado, listo, dato_rx);
endinterface

// File: rtl/spi_maestro_byte_divisor.sv
// spi_divisor_fase: phase timer, fin_fase pulses once every DIV clk cycles after reiniciar.
// Ports: clk, rst (async, active-low), reiniciar (restart count), fin_fase (end-of-phase pulse).
module spi_divisor_fase #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reiniciar,
    output logic fin_fase
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] ULT = W'(DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (reiniciar || fin_fase) ? '0 : cnt + 1'b1;
    end
    assign fin_fase = (cnt == ULT);
endmodule

// File: rtl/spi_maestro_byte.sv
// spi_maestro_byte: SPI mode-0 MSB-first word engine with programmable sclk divider.
// Ports: clk, rst (async, active-low), bus (spi_maestro_byte_if.master: inicio/dato_tx in,
// ocupado/listo/dato_rx out, sclk/mosi/cs_n out, miso in). All outputs come straight from flops.
module spi_maestro_byte
    import spi_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF,
    parameter int DIV   = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    spi_maestro_byte_if.master bus
);
    localparam int BW = $clog2(ANCHO + 1);
    localparam logic [BW-1:0] ULT = BW'(ANCHO);
    estado_t          estado, estado_n;
    logic             fin_fase, reiniciar;
    logic [ANCHO-1:0] tx, rx, rx_q;
    logic [BW-1:0]    bits;
    logic             sclk_q, cs_q, ocupado_q, listo_q;
    spi_divisor_fase #(.DIV(DIV)) u_div (
        .clk       (clk),
        .rst       (rst),
        .reiniciar (reiniciar),
        .fin_fase  (fin_fase)
    );
    always_comb begin
        estado_n = estado;
        case (estado)
            REPOSO:  estado_n = bus.inicio ? PREPARA : REPOSO;
            PREPARA: estado_n = fin_fase ? ALTO : PREPARA;
            ALTO:    estado_n = fin_fase ? BAJO : ALTO;
            BAJO:    estado_n = fin_fase ? ((bits < ULT) ? ALTO : REPOSO) : BAJO;
            default: estado_n = REPOSO;
        endcase
    end
    // every state change restarts the phase timer, including acceptance from REPOSO
    assign reiniciar = (estado_n != estado);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= REPOSO;
            tx        <= '0;
            rx        <= '0;
            rx_q      <= '0;
            bits      <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            estado    <= estado_n;
            sclk_q    <= (estado_n == ALTO);
            cs_q      <= (estado_n == REPOSO);
            ocupado_q <= (estado_n != REPOSO);
            listo_q   <= (estado == BAJO) && (estado_n == REPOSO);
            if (estado == REPOSO && estado_n == PREPARA) begin
                tx   <= bus.dato_tx;
                bits <= '0;
            end
            if (reiniciar && estado_n == ALTO) begin
                rx   <= {rx[ANCHO-2:0], bus.miso};
                bits <= bits + 1'b1;
            end
            // the final bit is not shifted out so mosi keeps the LSB until cs_n rises
            if (estado == ALTO && estado_n == BAJO && bits < ULT) tx <= tx << 1;
            // tx is cleared in REPOSO so mosi idles low
            if (estado == BAJO && estado_n == REPOSO) begin
                rx_q <= rx;
                tx   <= '0;
            end
        end
    end
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = tx[ANCHO-1];
    assign bus.cs_n    = cs_q;
    assign bus.ocupado = ocupado_q;
    assign bus.listo   = listo_q;
    assign bus.dato_rx = rx_q;
endmodule

// File: tb/tb_spi_maestro_byte.sv
// tb_spi_maestro_byte: self-checking bench for spi_maestro_byte (ANCHO=8, DIV=4).
module tb_spi_maestro_byte;
    localparam int ANCHO = 8;
    localparam int DIV = 4;
    localparam int FRAME = DIV * (1 + 2 * ANCHO);
    typedef struct {
        logic [7:0] tx;
        logic [7:0] s;
        bit         lb;
        bit         poke;
        logic [7:0] rx;
    } vec_t;
    logic clk, rst;
    bit lb;
    logic miso_drv;
    int n_chk, n_fail, cyc, t_listo;
    spi_maestro_byte_if #(.ANCHO(ANCHO)) bus ();
    spi_maestro_byte #(.ANCHO(ANCHO), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.miso = lb ? bus.mosi : miso_drv;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask
    function automatic logic [7:0] model(input logic [7:0] tx, input logic [7:0] s, input bit l);
        return l ? tx : s;
    endfunction
    task automatic chk_reset(input string nm);
        chk({nm, " outs"}, {bus.cs_n, bus.sclk, bus.mosi, bus.ocupado, bus.listo}, 5'b10000);
        chk({nm, " dato_rx"}, bus.dato_rx, 0);
    endtask
    task automatic idle(input int n, input string nm);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.ocupado || bus.listo || bus.sclk || !bus.cs_n) seen++;
        end
        chk(nm, seen, 0);
    endtask
    // Called at a negedge with the engine idle or in its listo cycle; returns at the next listo negedge.
    task automatic frame(input logic [7:0] tx, input logic [7:0] s, input bit l, input bit poke,
                         input logic [7:0] exp, input string nm);
        int n = 0, rises = 0, first = 0, viol = 0, low_run = 0;
        logic [7:0] got = 0;
        logic prev_s, prev_m;
        lb = l;
        miso_drv = s[7];
        bus.inicio = 1'b1;
        bus.dato_tx = tx;
        @(negedge clk);
        bus.inicio = 1'b0;
        chk({nm, " start"}, {bus.ocupado, bus.cs_n, bus.mosi, bus.sclk}, {3'b100 | {2'b00, tx[7]}, 1'b0});
        prev_s = bus.sclk;
        prev_m = bus.mosi;
        while (bus.ocupado && n < 4 * FRAME) begin
            n++;
            if (bus.sclk && !prev_s) begin
                if (rises < 8) got[7 - rises] = bus.mosi;
                if (rises == 0) first = n;
                rises++;
                miso_drv = (rises < 8) ? s[7 - rises] : 1'b0;
            end
            if (bus.mosi != prev_m && !(prev_s && !bus.sclk)) viol++;
            if (bus.cs_n || bus.listo) viol++;
            low_run = bus.sclk ? 0 : low_run + 1;
            prev_s = bus.sclk;
            prev_m = bus.mosi;
            bus.inicio = poke && (n == 10);
            bus.dato_tx = poke ? 8'h3C : 8'($urandom);
            @(negedge clk);
        end
        bus.inicio = 1'b0;
        t_listo = cyc;
        chk({nm, " busy_cycles"}, n, FRAME);
        chk({nm, " sclk_rises"}, rises, ANCHO);
        chk({nm, " mosi_bits"}, got, tx);
        chk({nm, " setup_hold"}, {viol, first, low_run}, {32'd0, 32'(DIV + 1), 32'(DIV)});
        chk({nm, " listo"}, {bus.listo, bus.cs_n, bus.ocupado, bus.mosi, bus.sclk}, 5'b11000);
        chk({nm, " dato_rx"}, bus.dato_rx, exp);
    endtask
    initial begin
        vec_t tab[5];
        int t1, k;
        logic p;
        logic [7:0] rtx, rs;
        bit rl;
        tab[0] = '{tx: 8'hA5, s: 8'h00, lb: 1'b1, poke: 1'b0, rx: 8'hA5};
        tab[1] = '{tx: 8'h00, s: 8'hFF, lb: 1'b0, poke: 1'b0, rx: 8'hFF};
        tab[2] = '{tx: 8'h81, s: 8'h6E, lb: 1'b0, poke: 1'b1, rx: 8'h6E};
        tab[3] = '{tx: 8'hFF, s: 8'h00, lb: 1'b0, poke: 1'b0, rx: 8'h00};
        tab[4] = '{tx: 8'h3C, s: 8'h96, lb: 1'b0, poke: 1'b0, rx: 8'h96};
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b0; lb = 1'b0; miso_drv = 1'b0;
        bus.inicio = 1'b0; bus.dato_tx = '0;
        repeat (3) @(negedge clk);
        chk_reset("power_on");
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            frame(tab[i].tx, tab[i].s, tab[i].lb, tab[i].poke, tab[i].rx, $sformatf("vec%0d", i));
            idle(20, $sformatf("vec%0d idle", i));
        end
        rst = 1'b0;
        #1 chk_reset("idle_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rtx = 8'($urandom);
            rs = 8'($urandom);
            rl = 1'($urandom);
            frame(rtx, rs, rl, 1'b0, model(rtx, rs, rl), $sformatf("rnd%0d", i));
            idle(2, $sformatf("rnd%0d idle", i));
        end
        frame(8'h11, 8'hE7, 1'b0, 1'b0, 8'hE7, "b2b_first");
        t1 = t_listo;
        bus.inicio = 1'b1;
        bus.dato_tx = 8'h5A;
        lb = 1'b1;
        @(negedge clk);
        chk("b2b cs_gap", {bus.cs_n, bus.ocupado, bus.listo}, 3'b010);
        bus.inicio = 1'b0;
        k = 0;
        while (!bus.listo && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("b2b listo_gap", cyc - t1, FRAME + 1);
        chk("b2b dato_rx", bus.dato_rx, 8'h5A);
        idle(5, "b2b idle");
        lb = 1'b1;
        bus.inicio = 1'b1;
        bus.dato_tx = 8'hF0;
        @(negedge clk);
        bus.inicio = 1'b0;
        k = 0; t1 = 0; p = 1'b0;
        while (t1 < 3 && k < 4 * FRAME) begin
            if (bus.sclk && !p) t1++;
            p = bus.sclk;
            if (t1 < 3) @(negedge clk);
            k++;
        end
        chk("abort reached_alto3", t1, 3);
        rst = 1'b0;
        #1 chk_reset("abort_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(FRAME + 10, "abort no_listo");
        frame(8'hC3, 8'h00, 1'b1, 1'b0, 8'hC3, "after_abort");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
